spi_cmd_master: RTL and testbench
=================================

# spi_cmd_master

SPI initiator that serializes queued 8-bit command bytes onto `sck`/`sdi`/`ce` and captures the byte returned on `sdo`. It is the driving end of the FPGA's command SPI link. In self-test builds it replaces the MCU and feeds the game's SPI receiver with move/piece command bytes (bits [1:0] move, [4:2] piece select, [5] move_valid) from on-chip stimulus. It runs in the HSOSC clock domain and contains a small transmit FIFO, so producers can enqueue several commands without waiting for the link.

## Interface
Parameters:
- `SCK_DIV`, 4: `clk` cycles per `sck` half-period; legal values are ≥1.
- `FIFO_DEPTH`, 4: transmit queue entries; must be a power of two, ≥2.
- `CE_SETUP`, 2: cycles `ce` is high before the first `sck` rise; legal values are ≥1.
- `CE_HOLD`, 2: cycles after the last `sck` fall before `ce` drops; legal values are ≥1.
- `CE_GAP`, 2: minimum `ce`-low cycles between frames, not counting the IDLE cycle.

Ports:
- `clk` in 1: system clock (HSOSC). One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `tx_data` in 8: command byte to enqueue.
- `tx_valid` in 1: enqueue request.
- `tx_ready` out 1: high when the FIFO is not full (registered from the occupancy count).
- `sck` out 1: SPI clock, mode 0 (idles low).
- `sdi` out 1: serial data to the responder, MSB first.
- `ce` out 1: chip enable, active-high for the whole frame.
- `sdo` in 1: serial data from the responder; already synchronous to `clk`.
- `rx_data` out 8: byte captured during the last frame.
- `rx_valid` out 1: single-cycle pulse when `rx_data` updates.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- Enqueue: `tx_valid && tx_ready` at a rising edge writes `tx_data`. When `tx_ready` is low, `tx_valid` is ignored and the byte is dropped.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: if the FIFO is non-empty at the edge, pop into the shift register, set `ce`=1, drive `sdi` with bit 7, go to SETUP. Otherwise stay in IDLE.
- SETUP: hold `sck`=0 for `CE_SETUP` cycles, then go to SHIFT.
- SHIFT: 8 bits, each `SCK_DIV` cycles low followed by `SCK_DIV` cycles high.
  - On the low→high transition, shift `sdo` into the receive register (LSB in).
  - On the high→low transition, present the next bit on `sdi`.
  - After the 8th high phase, `sck` returns to 0 and the FSM goes to HOLD.
- HOLD: `CE_HOLD` cycles with `ce`=1 and `sck`=0. Then `ce`=0, `rx_data` loads, `rx_valid` pulses for 1 cycle, and the FSM goes to GAP.
- GAP: `CE_GAP` cycles, then IDLE.
- Simultaneous push and pop: both take effect and the count is unchanged. A push while full is blocked even if a pop happens in the same cycle.
- Bit and divider counters: widths are `$clog2` of their ranges. Counters wrap only on reset or on frame completion.
- Reset mid-frame: at the next edge the FSM returns to IDLE and the FIFO is emptied. No `rx_valid` fires and the partial byte is discarded.
- Reset values: `sck`=0, `sdi`=0, `ce`=0, `rx_data`=0x00, `rx_valid`=0, `tx_ready`=1, `busy`=0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- `ce` rises on the edge after the IDLE pop, i.e. one cycle after the first accepted byte into an empty idle block.
- `ce`-high duration is exactly `CE_SETUP + 16·SCK_DIV + CE_HOLD` cycles, which is 68 at the defaults.
- `rx_valid` is asserted in the first `ce`-low cycle.
- Back-to-back frames: the next `ce` rise is `CE_GAP+1` cycles after `ce` falls, which is 3 at the defaults.
- `sdi` is stable for the full `sck`-high phase, with ≥`SCK_DIV` cycles of setup before each rise.

## Structure
- `spi_pkg` holds the FSM state enum (`spi_master_state_t`) and the command-byte field constants (`CMD_MOVE_LSB`, `CMD_PIECE_LSB`, `CMD_VALID_BIT`) shared with the receiver side.
- The FIFO is the sub-module `sync_fifo`, parameterized by width and depth, with `full`/`empty` outputs. The rest is one FSM with a divider counter and a bit counter.

## Test plan
- Single frame with `sdo` looped from `sdi`: push 0xA5 → `ce` high for 68 cycles, 8 `sck` rises, `sdi` carries 1,0,1,0,0,1,0,1, then `rx_data`=0xA5 with a 1-cycle `rx_valid`.
- Responder model shifting out 0x3C while 0x21 is sent (move=1, piece=0, valid=1) → `rx_data`=0x3C, and the model sees 0x21.
- FIFO full, `FIFO_DEPTH`=4: `tx_valid` held for 6 cycles from idle → 5 bytes accepted, `tx_ready` low after the 5th, and 5 frames are emitted in order.
- Back-to-back: 3 queued bytes → `ce` low for exactly 3 cycles between frames, and `busy` stays high until the last frame's GAP ends.
- Reset during bit 4 of a frame → next edge gives `ce`=0, `sck`=0, FIFO empty, no `rx_valid`. A fresh push afterwards transmits normally.
- `SCK_DIV`=1 boundary: push 0xFF → `ce`-high duration of 20 cycles, and `sck` toggles every cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the command SPI link: initiator FSM states and the
// command-byte field layout also used by the receiver side.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_master_state_t;

  localparam int CMD_MOVE_LSB  = 0;
  localparam int CMD_PIECE_LSB = 2;
  localparam int CMD_VALID_BIT = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read data and registered full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // A push is refused while full even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator: queues command bytes, shifts them out MSB first with
// a framed chip enable, and captures the responder's byte on sdo.
module spi_cmd_master
  import spi_pkg::*;
#(
  parameter int SCK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CE_SETUP   = 2,
  parameter int CE_HOLD    = 2,
  parameter int CE_GAP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sck,
  output logic       sdi,
  output logic       ce,
  input  logic       sdo,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam int CNT_MAX = max2(max2(SCK_DIV, CE_SETUP), max2(CE_HOLD, CE_GAP));
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  spi_master_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              sck_q, sck_d;
  logic              ce_q, ce_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (tx_data),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    ce_d       = ce_q;
    rx_valid_d = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_dout;
          rx_shift_d = '0;
          ce_d       = 1'b1;
          cnt_d      = '0;
          bit_d      = '0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CE_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d      = 1'b1;
            rx_shift_d = {rx_shift_q[6:0], sdo};
          end else begin
            // sdi is the shift register MSB, so shifting presents the next bit.
            sck_d   = 1'b0;
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CE_HOLD - 1)) begin
          cnt_d      = '0;
          ce_d       = 1'b0;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = (CE_GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(CE_GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Queue occupancy after this edge is non-zero iff it is now, or a push lands.
    busy_d = (state_d != ST_IDLE) || !fifo_empty || push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      ce_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      ce_q       <= ce_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign sck      = sck_q;
  assign sdi      = shift_q[7];
  assign ce       = ce_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: default instance with a responder model
// plus a SCK_DIV=1 instance in loopback.
module tb_spi_cmd_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, sck, sdi, ce, sdo, rx_valid, busy;
  logic [7:0] rx_data;

  logic [7:0] tx_data_1 = 8'h00;
  logic       tx_valid_1 = 1'b0;
  logic       tx_ready_1, sck_1, sdi_1, ce_1, sdo_1, rx_valid_1, busy_1;
  logic [7:0] rx_data_1;

  spi_cmd_master dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sck(sck), .sdi(sdi), .ce(ce), .sdo(sdo),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  spi_cmd_master #(.SCK_DIV(1)) dut_div1 (
    .clk(clk), .reset(reset), .tx_data(tx_data_1), .tx_valid(tx_valid_1),
    .tx_ready(tx_ready_1), .sck(sck_1), .sdi(sdi_1), .ce(ce_1), .sdo(sdo_1),
    .rx_data(rx_data_1), .rx_valid(rx_valid_1), .busy(busy_1)
  );

  assign sdo_1 = sdi_1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Responder model and scoreboard
  logic       loop_mode = 1'b1;
  logic [7:0] resp_pattern = 8'h00;
  logic [7:0] resp_sh = 8'h00;
  logic       resp_sdo = 1'b0;
  logic [7:0] seen = 8'h00;
  logic       ce_prev = 1'b0, sck_prev = 1'b0, rxv_prev = 1'b0;
  int         rises = 0, ce_cnt = 0, low_cnt = 0, rx_count = 0;
  int         cyc = 0, last_rxv_cyc = 0, busy_low_cnt = 0;
  bit         gap_check_en = 1'b0, b2b_en = 1'b0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  assign sdo = loop_mode ? sdi : resp_sdo;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ce_prev  <= ce;
    sck_prev <= sck;
    rxv_prev <= rx_valid;
    if (ce && !ce_prev) begin
      resp_sh  <= resp_pattern;
      resp_sdo <= resp_pattern[7];
      seen     <= 8'h00;
      rises    <= 0;
      ce_cnt   <= 1;
      if (gap_check_en) check_eq("ce_gap", low_cnt, 3);
      low_cnt  <= 0;
    end else begin
      if (ce) ce_cnt <= ce_cnt + 1;
      else    low_cnt <= low_cnt + 1;
      if (sck && !sck_prev) begin
        seen  <= {seen[6:0], sdi};
        rises <= rises + 1;
      end
      if (!sck && sck_prev) begin
        resp_sh  <= {resp_sh[6:0], 1'b0};
        resp_sdo <= resp_sh[6];
      end
    end
    if (b2b_en && !busy) busy_low_cnt <= busy_low_cnt + 1;
    if (rx_valid) begin
      rx_count     <= rx_count + 1;
      last_rxv_cyc <= cyc;
      check_eq("rx_valid_width", rxv_prev, 0);
      check_eq("rx_ce_low", ce, 0);
      check_eq("ce_high_len", ce_cnt, 68);
      check_eq("sck_rises", rises, 8);
      if (exp_rx_q.size() == 0) begin
        check_eq("rx_unexpected", exp_rx_q.size(), 1);
      end else begin
        check_eq("rx_data", rx_data, exp_rx_q.pop_front());
        check_eq("resp_seen", seen, exp_tx_q.pop_front());
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic [7:0] exp_rx);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    check_eq("tx_ready", tx_ready, 1);
    exp_tx_q.push_back(b);
    exp_rx_q.push_back(exp_rx);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int k = 0;
    while (rx_count < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("frames_done", rx_count >= target, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || ce) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_reached", busy, 0);
  endtask

  initial begin
    logic [7:0] cmd;
    int k, rxc, ce_len, toggles, highs;
    logic prev;

    repeat (3) @(negedge clk);
    check_eq("rst_sck", sck, 0);
    check_eq("rst_sdi", sdi, 0);
    check_eq("rst_ce", ce, 0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_ce", ce, 0);

    // Single loopback frame
    push_byte(8'hA5, 8'hA5);
    wait_frames(1);
    wait_idle();

    // Responder returns 0x3C while a move command is sent
    cmd = 8'((1 << CMD_VALID_BIT) | (0 << CMD_PIECE_LSB) | (1 << CMD_MOVE_LSB));
    loop_mode    = 1'b0;
    resp_pattern = 8'h3C;
    push_byte(cmd, 8'h3C);
    wait_frames(2);
    wait_idle();
    loop_mode = 1'b1;

    // FIFO full: tx_valid held 6 cycles, 5 accepted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_data  = 8'(8'h10 + i);
      tx_valid = 1'b1;
      check_eq($sformatf("full_ready_%0d", i), tx_ready, (i < 5) ? 1 : 0);
      if (i < 5) begin
        exp_tx_q.push_back(8'(8'h10 + i));
        exp_rx_q.push_back(8'(8'h10 + i));
      end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_frames(7);
    wait_idle();

    // Back-to-back frames
    push_byte(8'h81, 8'h81);
    push_byte(8'h42, 8'h42);
    push_byte(8'h18, 8'h18);
    b2b_en = 1'b1;
    k = 0;
    while (!ce && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    gap_check_en = 1'b1;
    wait_frames(10);
    gap_check_en = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("busy_fall_delay", cyc - last_rxv_cyc, 2);
    b2b_en = 1'b0;
    check_eq("busy_low_b2b", busy_low_cnt, 0);
    wait_idle();

    // Reset mid-frame
    push_byte(8'h5A, 8'h5A);
    push_byte(8'h77, 8'h77);
    k = 0;
    while (!(ce && rises >= 4) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("reached_bit4", rises >= 4, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_ce", ce, 0);
    check_eq("mid_rst_sck", sck, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_tx_ready", tx_ready, 1);
    check_eq("mid_rst_rx_valid", rx_valid, 0);
    exp_tx_q.delete();
    exp_rx_q.delete();
    rxc = rx_count;
    repeat (200) @(negedge clk);
    check_eq("no_rx_after_rst", rx_count, rxc);
    check_eq("fifo_flushed", busy, 0);
    push_byte(8'hC3, 8'hC3);
    wait_frames(rxc + 1);
    wait_idle();

    // SCK_DIV=1 instance
    @(negedge clk);
    tx_data_1  = 8'hFF;
    tx_valid_1 = 1'b1;
    check_eq("div1_tx_ready", tx_ready_1, 1);
    @(negedge clk);
    tx_valid_1 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ce_1 && k < 50);
    ce_len = 0; toggles = 0; highs = 0; prev = 1'b0; k = 0;
    while (ce_1 && k < 200) begin
      ce_len++;
      if (sck_1 != prev) toggles++;
      if (sck_1) highs++;
      prev = sck_1;
      @(negedge clk);
      k++;
    end
    check_eq("div1_ce_len", ce_len, 20);
    check_eq("div1_sck_toggles", toggles, 16);
    check_eq("div1_sck_highs", highs, 8);
    check_eq("div1_rx_valid", rx_valid_1, 1);
    check_eq("div1_rx_data", rx_data_1, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
